// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit lookahead group per stage,
// group carry registered forward, valid/ready handshake with a single global advance.
`timescale 1ns/1ps

module cla_pipe_addsub #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int S = WIDTH / BLOCK;

  // Operands shift down one group per stage so the live group is always at bit 0;
  // finished sum groups enter from the top and land in place after S stages.
  typedef struct packed {
    logic             valid;
    logic             sub;
    logic             carry;
    logic             ovf;
    logic             zero;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
  } stage_t;

  // Returns {carry into group MSB, group carry-out, group sum}; every carry is a
  // flat sum of generate/propagate products of the group inputs.
  function automatic logic [BLOCK+1:0] group_cla(
    input logic [BLOCK-1:0] ga,
    input logic [BLOCK-1:0] gb,
    input logic             gc
  );
    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK:0]   gx;
    logic [BLOCK:0]   c;
    logic             term;
    logic             any;
    g     = ga & gb;
    p     = ga ^ gb;
    gx    = {g, gc};
    c     = '0;
    c[0]  = gc;
    for (int i = 0; i < BLOCK; i++) begin
      any = 1'b0;
      for (int j = 0; j <= i + 1; j++) begin
        term = gx[j];
        for (int m = j; m <= i; m++) term = term & p[m];
        any = any | term;
      end
      c[i+1] = any;
    end
    return {c[BLOCK-1], c[BLOCK], p ^ c[BLOCK-1:0]};
  endfunction

  stage_t             st_q [S];
  stage_t             st_d [S];
  stage_t             src  [S];
  logic [BLOCK+1:0]   grp  [S];
  logic               advance;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  always_comb begin
    // NOTE: every element is defaulted before any conditional use, so no latches.
    for (int k = 0; k < S; k++) begin
      src[k] = '0;
      st_d[k] = '0;
      grp[k] = '0;
    end

    src[0].valid = in_valid;
    src[0].sub   = sub;
    src[0].carry = sub ? ~cin : cin;
    src[0].zero  = 1'b1;
    src[0].a     = a;
    src[0].b     = sub ? ~b : b;
    for (int k = 1; k < S; k++) src[k] = st_q[k-1];

    for (int k = 0; k < S; k++) begin
      grp[k]        = group_cla(src[k].a[BLOCK-1:0], src[k].b[BLOCK-1:0], src[k].carry);
      st_d[k].valid = src[k].valid;
      st_d[k].sub   = src[k].sub;
      st_d[k].carry = grp[k][BLOCK];
      // Only the last group's value survives to the output stage.
      st_d[k].ovf   = grp[k][BLOCK+1] ^ grp[k][BLOCK];
      st_d[k].zero  = src[k].zero & (grp[k][BLOCK-1:0] == '0);
      st_d[k].a     = src[k].a >> BLOCK;
      st_d[k].b     = src[k].b >> BLOCK;
      st_d[k].sum   = (src[k].sum >> BLOCK) | (WIDTH'(grp[k][BLOCK-1:0]) << (WIDTH - BLOCK));
    end
  end

  // NOTE: state is updated with non-blocking '<=' only; the data fields are reset
  // as well so sum and flags read 0 out of reset, not just the valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < S; k++) st_q[k] <= '0;
    end else if (advance) begin
      for (int k = 0; k < S; k++) st_q[k] <= st_d[k];
    end
  end

  assign out_valid = st_q[S-1].valid;
  assign sum       = st_q[S-1].sum;
  assign cout      = st_q[S-1].carry ^ st_q[S-1].sub;
  assign ovf       = st_q[S-1].ovf;
  assign zero      = st_q[S-1].zero;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Directed and streaming bench for cla_pipe_addsub at 32/8, 16/4 and 8/8 with an
// in-order scoreboard per instance fed from a golden arithmetic model.
`timescale 1ns/1ps

module tb_cla_pipe_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid;
  logic [31:0] a_in, b_in;
  logic        cin_in, sub_in;
  logic        out_ready0, out_ready_s;

  logic ir0, ov0, co0, of0, z0; logic [31:0] s0;
  logic ir1, ov1, co1, of1, z1; logic [15:0] s1;
  logic ir2, ov2, co2, of2, z2; logic [7:0]  s2;

  cla_pipe_addsub #(.WIDTH(32), .BLOCK(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0),
    .a(a_in), .b(b_in), .cin(cin_in), .sub(sub_in),
    .out_valid(ov0), .out_ready(out_ready0), .sum(s0), .cout(co0), .ovf(of0), .zero(z0));

  cla_pipe_addsub #(.WIDTH(16), .BLOCK(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
    .a(a_in[15:0]), .b(b_in[15:0]), .cin(cin_in), .sub(sub_in),
    .out_valid(ov1), .out_ready(out_ready_s), .sum(s1), .cout(co1), .ovf(of1), .zero(z1));

  cla_pipe_addsub #(.WIDTH(8), .BLOCK(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2),
    .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin_in), .sub(sub_in),
    .out_valid(ov2), .out_ready(out_ready_s), .sum(s2), .cout(co2), .ovf(of2), .zero(z2));

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Golden model: plain wide arithmetic, result packed as {cout, ovf, zero, sum}.
  function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic ci, input logic s, input int w);
    logic [63:0] mask, xa, ye, full;
    logic [31:0] r;
    logic        co, ov;
    mask = (64'd1 << w) - 64'd1;
    xa   = {32'd0, x} & mask;
    ye   = (s ? ~{32'd0, y} : {32'd0, y}) & mask;
    full = xa + ye + {63'd0, (s ? ~ci : ci)};
    r    = full[31:0] & mask[31:0];
    co   = full[w];
    ov   = (xa[w-1] == ye[w-1]) && (r[w-1] != xa[w-1]);
    return {(s ? ~co : co), ov, (r == 32'd0), r};
  endfunction

  logic [34:0] q0[$], q1[$], q2[$];
  int acc_cnt0 = 0;
  int out_cnt0 = 0;

  always @(negedge clk) begin : mon0
    if (!rst_n) q0.delete();
    else begin
      if (ov0 && out_ready0) begin
        out_cnt0++;
        if (q0.size() == 0) check("sb0_unexpected_beat", {63'd0, ov0}, 64'd0);
        else check("sb0_result", {29'd0, co0, of0, z0, s0}, {29'd0, q0.pop_front()});
      end
      if (in_valid && ir0) begin
        acc_cnt0++;
        q0.push_back(model(a_in, b_in, cin_in, sub_in, 32));
      end
    end
  end

  always @(negedge clk) begin : mon1
    if (!rst_n) q1.delete();
    else begin
      if (ov1 && out_ready_s) begin
        if (q1.size() == 0) check("sb1_unexpected_beat", {63'd0, ov1}, 64'd0);
        else check("sb1_result", {29'd0, co1, of1, z1, 16'd0, s1}, {29'd0, q1.pop_front()});
      end
      if (in_valid && ir1) q1.push_back(model(a_in, b_in, cin_in, sub_in, 16));
    end
  end

  always @(negedge clk) begin : mon2
    if (!rst_n) q2.delete();
    else begin
      if (ov2 && out_ready_s) begin
        if (q2.size() == 0) check("sb2_unexpected_beat", {63'd0, ov2}, 64'd0);
        else check("sb2_result", {29'd0, co2, of2, z2, 24'd0, s2}, {29'd0, q2.pop_front()});
      end
      if (in_valid && ir2) q2.push_back(model(a_in, b_in, cin_in, sub_in, 8));
    end
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [34:0] exp;  // {cout, ovf, zero, sum}
  } vec_t;

  vec_t vecs[9];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat;
    int base_acc, base_out, stale, guard;
    logic [35:0] hold;

    vecs[0] = '{32'hFFFFFFD9, 32'h00000062, 1'b0, 1'b0, {1'b1, 1'b0, 1'b0, 32'h0000003B}};
    vecs[1] = '{32'h00000062, 32'hFFFFFFD9, 1'b0, 1'b1, {1'b1, 1'b0, 1'b0, 32'h00000089}};
    vecs[2] = '{32'h12345678, 32'h12345678, 1'b0, 1'b1, {1'b0, 1'b0, 1'b1, 32'h00000000}};
    vecs[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, {1'b0, 1'b1, 1'b0, 32'h80000000}};
    vecs[4] = '{32'h00000005, 32'h00000003, 1'b1, 1'b1, {1'b0, 1'b0, 1'b0, 32'h00000001}};
    vecs[5] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, {1'b1, 1'b0, 1'b1, 32'h00000000}};
    vecs[6] = '{32'h00000000, 32'h00000001, 1'b0, 1'b1, {1'b1, 1'b0, 1'b0, 32'hFFFFFFFF}};
    vecs[7] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, {1'b0, 1'b1, 1'b0, 32'h7FFFFFFF}};
    vecs[8] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, {1'b1, 1'b1, 1'b1, 32'h00000000}};

    rst_n = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0; cin_in = 1'b0; sub_in = 1'b0;
    out_ready0 = 1'b0; out_ready_s = 1'b1;

    #12;
    check("rst_out_valid", {63'd0, ov0}, 64'd0);
    check("rst_sum_flags", {29'd0, co0, of0, z0, s0}, 64'd0);
    check("rst_in_ready", {63'd0, ir0}, 64'd1);
    check("rst_out_valid_s1", {63'd0, ov2}, 64'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    out_ready0 = 1'b1;
    @(posedge clk); #1;

    // Directed vectors: latency S-1 edges after the accept edge, then the result.
    for (int i = 0; i < 9; i++) begin
      a_in = vecs[i].a; b_in = vecs[i].b; cin_in = vecs[i].cin; sub_in = vecs[i].sub;
      in_valid = 1'b1;
      check($sformatf("vec%0d_in_ready", i), {63'd0, ir0}, 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!ov0 && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd3);
      check($sformatf("vec%0d_result", i), {29'd0, co0, of0, z0, s0}, {29'd0, vecs[i].exp});
    end

    // 16 back-to-back beats: all delivered exactly 3 edges after the last accept.
    repeat (3) @(posedge clk); #1;
    base_out = out_cnt0;
    for (int i = 0; i < 16; i++) begin
      a_in = $urandom(); b_in = $urandom();
      cin_in = 1'($urandom_range(0, 1)); sub_in = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      check("stream_in_ready", {63'd0, ir0}, 64'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("stream_one_per_cycle", 64'(out_cnt0 - base_out), 64'd16);

    // Backpressure: drop out_ready for 3 cycles while a sender streams 12 beats.
    repeat (2) @(posedge clk); #1;
    base_acc = acc_cnt0;
    base_out = out_cnt0;
    fork
      begin : sender
        logic took;
        int   g;
        for (int i = 0; i < 12; i++) begin
          a_in = $urandom(); b_in = $urandom();
          cin_in = 1'($urandom_range(0, 1)); sub_in = 1'($urandom_range(0, 1));
          in_valid = 1'b1;
          g = 0;
          do begin
            @(negedge clk);
            took = ir0;
            @(posedge clk); #1;
            g++;
          end while (!took && g < 50);
          if (!took) check("bp_send_timeout", 64'd0, 64'd1);
        end
        in_valid = 1'b0;
      end
      begin : staller
        repeat (6) @(posedge clk); #1;
        check("bp_pre_out_valid", {63'd0, ov0}, 64'd1);
        out_ready0 = 1'b0;
        hold = {ov0, co0, of0, z0, s0};
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          check("bp_in_ready_low", {63'd0, ir0}, 64'd0);
          check("bp_output_hold", {28'd0, ov0, co0, of0, z0, s0}, {28'd0, hold});
          @(posedge clk); #1;
        end
        out_ready0 = 1'b1;
      end
    join
    guard = 0;
    while (q0.size() != 0 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    @(negedge clk); #1;
    check("bp_accepted", 64'(acc_cnt0 - base_acc), 64'd12);
    check("bp_delivered", 64'(out_cnt0 - base_out), 64'd12);

    // Reset with beats in flight: outputs clear at once, nothing stale afterwards.
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      a_in = $urandom(); b_in = $urandom(); cin_in = 1'b0; sub_in = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      check("rst_stream_in_ready", {63'd0, ir0}, 64'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #1;
    check("rst_pre_out_valid", {63'd0, ov0}, 64'd1);
    check("rst_pre_out_valid_s1", {63'd0, ov2}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", {63'd0, ov0}, 64'd0);
    check("rst_mid_out_valid_w16", {63'd0, ov1}, 64'd0);
    check("rst_mid_out_valid_s1", {63'd0, ov2}, 64'd0);
    check("rst_mid_sum_flags", {29'd0, co0, of0, z0, s0}, 64'd0);
    check("rst_mid_in_ready", {63'd0, ir0}, 64'd1);
    repeat (2) @(posedge clk); #3;
    rst_n = 1'b1;
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (ov0 || ov1 || ov2) stale++;
    end
    check("rst_no_stale_beats", 64'(stale), 64'd0);

    repeat (2) @(posedge clk); #1;
    check("sb_queues_empty", 64'(q0.size() + q1.size() + q2.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/cla_pipe_addsub.md
# cla_pipe_addsub

Parametrised, pipelined carry-lookahead adder/subtractor, the successor to the fixed 32-bit CLA in the integer-add path. Operands are split into BLOCK-bit lookahead groups. Each pipeline stage resolves one group and registers the group carry forward, so WIDTH is decoupled from cycle time. It accepts one operation per cycle under a valid/ready handshake and adds subtract mode plus carry/borrow, signed-overflow and zero flags. It sits between operand fetch and writeback in the integer execution unit.

## Interface
- WIDTH, 32: operand and result width. Must satisfy WIDTH % BLOCK == 0.
- BLOCK, 8: bits per lookahead group, ≥1. Also sets the stage count S = WIDTH/BLOCK.
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (add) / borrow-in (sub)
- sub  in  1  0 = A+B+cin; 1 = A−B−cin
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result
- cout  out  1  add: carry-out; sub: borrow-out
- ovf  out  1  two's-complement overflow
- zero  out  1  sum == 0

## Operation
- Effective operands:
  - b_eff = sub ? ~b : b
  - c0 = sub ? ~cin : cin
- Raw result: {c_out, sum} = a + b_eff + c0, computed modulo 2^WIDTH.
- Flags:
  - cout = sub ? ~c_out : c_out
  - ovf = carry-into-MSB XOR c_out
  - zero = (sum == 0)
- Group g (0..S−1) covers bits [g·BLOCK +: BLOCK].
  - Each group uses internal generate/propagate lookahead; there is no bit-ripple inside a group.
  - Group g is computed in stage g+1 from the carry registered by stage g. Stage 1 uses c0.
- Operand skew:
  - Stage k carries forward the unprocessed upper groups of a and b_eff, plus sub.
  - Stage k also carries the already-computed lower sum groups.
  - Stage S holds the complete sum, cout, ovf and zero.
- Each stage has a valid bit. A global advance = !out_valid || out_ready.
  - When advance is high, every stage loads from the previous stage, and stage 1 loads from the ports, with valid = in_valid.
  - When advance is low, all stages hold.
- in_ready = advance. It is combinational from out_valid and out_ready.
- Bubbles are not compacted; a bubble occupies its stage like a beat.
- WIDTH == BLOCK gives S = 1: a single registered CLA with the same handshake.

## Timing
- Reset (rst_n low, asynchronous): all stage valid bits and data registers clear.
  - Outputs: out_valid=0, sum=0, cout=0, ovf=0, zero=0.
  - in_ready=1 once out_valid=0.
- Reset mid-operation discards all in-flight beats. No output beat appears for them after release.
- Latency: a beat accepted on edge N (in_valid && in_ready) appears with out_valid=1 after edge N+S−1. The defaults give S=4.
- Throughput: 1 beat/cycle while out_ready stays high.
- Stall: with out_valid=1 and out_ready=0, sum/cout/ovf/zero/out_valid hold bit-stable and in_ready=0. Port inputs are ignored until advance.
- Simultaneous events: out_valid && out_ready && in_valid in one cycle means the output is consumed and the new beat is accepted on the same edge.
- Input data need only be stable while in_valid && in_ready.

## Test plan
- Add, defaults: a=FFFFFFD9, b=00000062, cin=0, sub=0 → after S=4 cycles sum=0000003B, cout=1, ovf=0, zero=0.
- Subtract: a=00000062, b=FFFFFFD9, sub=1, cin=0 → sum=00000089, cout=1 (borrow), ovf=0. Then a=b=12345678, sub=1 → sum=0, zero=1, cout=0.
- Overflow and borrow-in:
  - a=7FFFFFFF, b=1, add → sum=80000000, ovf=1, cout=0.
  - a=5, b=3, sub=1, cin=1 → sum=1, cout=0.
- Back-to-back stream of 16 random beats with out_ready=1 → results match a golden model in order, one per cycle, first one 4 cycles after the first accept.
- Backpressure: stream beats and drop out_ready for 3 cycles mid-stream → in_ready=0 during the stall, the output holds stable, and no beat is lost or duplicated.
- Reset mid-stream with 3 beats in flight → out_valid=0 immediately, with no stale beats after release. Repeat with WIDTH=16, BLOCK=4 and WIDTH=8, BLOCK=8 (S=1, latency 1).
